// File: rtl/binary_sub_11_serial.sv
// ---------------------------------------------------------------------------
// binary_sub_11_serial
//   Bit-serial subtractor D = A - B, one bit per enabled clock, built around
//   a single full-adder cell. A + ~B + 1 is used, so the +1 is preloaded into
//   the carry. Operands are captured on an accepted start. D and borrow are
//   registered and held until the next completion.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   en      clock enable; 0 freezes all computation state
//   start   request, sampled only when idle and en=1
//   A, B    minuend / subtrahend, captured on accepted start
//   busy    high while a subtraction is in progress
//   done    one-cycle pulse when D/borrow update
//   D       difference modulo 2^WIDTH
//   borrow  1 when A < B (unsigned)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; D/borrow hold the last result
// RUN   | shifting operands through the FA cell, one bit per enabled edge
// ---------------------------------------------------------------------------
module binary_sub_11_serial #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             s;
  logic             cout;
  logic [WIDTH-1:0] r_nxt;

  // The single full-adder cell plus the result shift-in.
  always_comb begin
    s     = a_sh[0] ^ b_sh[0] ^ carry;
    cout  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    r_nxt = {s, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      borrow <= 1'b0;
    end else begin
      // done is a pulse and drops on the next edge even while stalled.
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              a_sh  <= A;
              b_sh  <= ~B;
              carry <= 1'b1;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
          RUN: begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= r_nxt;
            carry <= cout;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              // Final bit goes straight into D; no carry-out means A < B.
              D      <= r_nxt;
              borrow <= ~cout;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_binary_sub_11_serial.sv
module tb_binary_sub_11_serial;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         borrow;

  binary_sub_11_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .D      (D),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one accepted request at a negedge while idle; expected result is
  // pushed to the scoreboard. Returns at the negedge after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    exp_t e;
    A     = a;
    B     = b;
    start = 1'b1;
    en    = 1'b1;
    e.d   = a - b;
    e.br  = (a < b);
    e.acc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  // Scoreboard side: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_pulse_width", done, 0);
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("D", D, e.d);
          check("borrow", borrow, e.br);
          check("busy_at_done", busy, 0);
          if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int saved_done;
    rst_n = 1'b0;
    en    = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_D", D, 0);
    check("rst_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // 100 - 37: busy for 11 samples, then done.
    do_op(11'd100, 11'd37, 11);
    for (int i = 0; i < 11; i++) begin
      check("busy_run", busy, 1);
      @(negedge clk);
    end
    check("done_after_11", done, 1);

    @(negedge clk);
    do_op(11'd37, 11'd100, 11);
    wait_done(20);
    do_op(11'd0, 11'd1, 11);
    wait_done(20);
    do_op(11'd2047, 11'd2047, 11);
    wait_done(20);
    do_op(11'd0, 11'd0, 11);
    wait_done(20);

    // Stall 3 cycles mid-run.
    @(negedge clk);
    do_op(11'd1500, 11'd499, 14);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_hold_stall", busy, 1);
    en = 1'b1;
    wait_done(30);

    // Start during RUN is ignored; start in the done cycle is accepted.
    @(negedge clk);
    do_op(11'd10, 11'd3, 11);
    repeat (3) @(negedge clk);
    A     = 11'd5;
    B     = 11'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    do_op(11'd5, 11'd9, 11);
    wait_done(20);

    // Reset at bit 5 abandons the operation.
    @(negedge clk);
    do_op(11'd300, 11'd200, 11);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_D", D, 0);
    check("midrst_borrow", borrow, 0);
    sb.delete();
    saved_done = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", n_done, saved_done);
    check("idle_after_rst", busy, 0);

    // Random regression with random stalls.
    for (int k = 0; k < 1000; k++) begin
      int n;
      do_op(W'($urandom), W'($urandom), -1);
      n = 0;
      while (!done && n < 200) begin
        en = ($urandom_range(3) != 0);
        @(negedge clk);
        n++;
      end
      if (!done) check("rand_done_timeout", done, 1);
      en = 1'b1;
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
